pipelined_barrel_shifter: RTL and testbench



---
 rtl/barrel_pkg.sv | 12 +
 rtl/pipelined_barrel_shifter_shift_level.sv | 15 +
 rtl/pipelined_barrel_shifter.sv | 57 +++++
 tb/tb_pipelined_barrel_shifter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// barrel_pkg: shifter mode encodings and bit-reverse helper
package barrel_pkg;
  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;
  function automatic logic [63:0] bit_rev(input logic [63:0] d, input int w);
    logic [63:0] r;
    r = {<<{d}};
    return r >> (64 - w);
  endfunction
endpackage

// File: rtl/pipelined_barrel_shifter_shift_level.sv
// shift_level: one mux level shifting right by 2^LEVEL with fill or rotate
module shift_level #(
  parameter int WIDTH = 8,
  parameter int LEVEL = 0
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             rot,
  input  logic             fill,
  output logic [WIDTH-1:0] q
);
  localparam int S = 1 << LEVEL;
  // Pass through, rotate the low bits around, or shift in the fill bit
  always_comb q = !en ? d : rot ? {d[S-1:0], d[WIDTH-1:S]} : {{S{fill}}, d[WIDTH-1:S]};
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: four-mode barrel shifter with optional per-level registers and valid/ready flow control
module pipelined_barrel_shifter
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PIPE  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_zero
);
  localparam int SHW = $clog2(WIDTH);
  logic             adv;
  logic [WIDTH-1:0] fin;
  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
    return WIDTH'(bit_rev(64'(x), WIDTH));
  endfunction
  // The whole pipeline moves only when the output register is free or being drained
  always_comb adv = !out_valid || out_ready;
  // Input side accepts exactly when the pipeline advances
  always_comb in_ready = adv;
  for (genvar k = 0; k < SHW; k++) begin : g
    logic             v, s;
    logic [1:0]       m;
    logic [SHW-1-k:0] a;
    logic [WIDTH-1:0] d, q;
    shift_level #(.WIDTH(WIDTH), .LEVEL(k)) u_lvl (
      .d(d), .en(a[0]), .rot(m == MODE_ROR), .fill(m == MODE_ASR && s), .q(q)
    );
    if (k == 0) begin : g_src
      // LSL runs through the right-shift chain on the bit-reversed operand
      always_comb {v, m, s, a, d} = {in_valid, in_mode, in_data[WIDTH-1], in_shamt, (in_mode == MODE_LSL) ? rev(in_data) : in_data};
    end else if (PIPE != 0) begin : g_reg
      // Level register: sideband and the not-yet-used shamt bits travel with the data
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {v, m, s, a, d} <= '0;
        else if (adv) {v, m, s, a, d} <= {g[k-1].v, g[k-1].m, g[k-1].s, g[k-1].a[SHW-k:1], g[k-1].q};
    end else begin : g_comb
      // Unregistered level boundary
      always_comb {v, m, s, a, d} = {g[k-1].v, g[k-1].m, g[k-1].s, g[k-1].a[SHW-k:1], g[k-1].q};
    end
  end
  // Undo the LSL bit reversal after the last level
  always_comb fin = (g[SHW-1].m == MODE_LSL) ? rev(g[SHW-1].q) : g[SHW-1].q;
  // Output register with the zero flag computed from the final result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {out_valid, out_zero, out_data} <= '0;
    else if (adv) {out_valid, out_zero, out_data} <= {g[SHW-1].v, fin == '0, fin};
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed and randomized checks of both pipeline configurations against a shift model
module tb_pipelined_barrel_shifter;
  typedef logic [7:0] q_t [$];
  logic       clk = 0, rst_n = 0;
  logic       iv [2], ir [2], ov [2], ordy [2], oz [2];
  logic [7:0] id [2], od [2];
  logic [2:0] ish [2];
  logic [1:0] im [2];
  q_t         q [2];
  int         n_cmp = 0, n_err = 0;
  int         sent [2], got [2];

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(8), .PIPE(0)) u_p0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .in_shamt(ish[0]), .in_mode(im[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od[0]), .out_zero(oz[0])
  );
  pipelined_barrel_shifter #(.WIDTH(8), .PIPE(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .in_shamt(ish[1]), .in_mode(im[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od[1]), .out_zero(oz[1])
  );

  function automatic logic [7:0] model(logic [7:0] d, logic [2:0] s, logic [1:0] m);
    logic [15:0] dd;
    dd = {d, d} >> s;
    if (m == 2'b00) return d << s;
    if (m == 2'b01) return d >> s;
    if (m == 2'b10) return $signed(d) >>> s;
    return dd[7:0];
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rnd(int u);
    id[u] = 8'($urandom);
    ish[u] = 3'($urandom);
    im[u] = 2'($urandom);
  endtask

  task automatic cyc();
    logic       hold [2];
    logic [7:0] hd [2];
    logic [7:0] e;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      hold[u] = ov[u] && !ordy[u];
      hd[u] = od[u];
      if (ov[u] && ordy[u]) begin
        if (q[u].size() == 0) chk("spurious_ov", ov[u], 0);
        else begin
          e = q[u].pop_front();
          chk("sb_data", od[u], e);
          chk("sb_zero", oz[u], e == 0);
          got[u]++;
        end
      end
      if (iv[u] && ir[u]) begin
        q[u].push_back(model(id[u], ish[u], im[u]));
        sent[u]++;
      end
    end
    @(posedge clk); #1;
    for (int u = 0; u < 2; u++)
      if (hold[u]) begin
        chk("stall_ov", ov[u], 1);
        chk("stall_od", od[u], hd[u]);
      end
  endtask

  task automatic dir0(string tag, logic [7:0] d, logic [2:0] s, logic [1:0] m, logic [7:0] exp);
    iv[0] = 1; id[0] = d; ish[0] = s; im[0] = m;
    cyc();
    iv[0] = 0;
    chk({tag, "_ov"}, ov[0], 1);
    chk(tag, od[0], exp);
    chk({tag, "_zero"}, oz[0], exp == 0);
    cyc();
  endtask

  task automatic drain();
    iv = '{0, 0};
    ordy = '{1, 1};
    for (int c = 0; c < 20 && (q[0].size() != 0 || q[1].size() != 0); c++) cyc();
    for (int u = 0; u < 2; u++) begin
      chk("drain_q", q[u].size(), 0);
      chk("drain_cnt", got[u], sent[u]);
    end
  endtask

  initial begin
    logic [7:0] hd;
    iv = '{0, 0}; ordy = '{1, 1}; id = '{0, 0}; ish = '{0, 0}; im = '{0, 0};
    sent = '{0, 0}; got = '{0, 0};
    @(posedge clk); #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_ov", ov[u], 0);
      chk("rst_od", od[u], 0);
      chk("rst_oz", oz[u], 0);
    end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("rel_ir0", ir[0], 1);
    chk("rel_ir1", ir[1], 1);

    dir0("lsl3", 8'b1001_0110, 3, 2'b00, 8'b1011_0000);
    dir0("lsr3", 8'b1001_0110, 3, 2'b01, 8'b0001_0010);
    dir0("asr3", 8'b1001_0110, 3, 2'b10, 8'b1111_0010);
    dir0("ror3", 8'b1001_0110, 3, 2'b11, 8'b1101_0010);
    for (int m = 0; m < 4; m++) dir0("sh0", 8'hA5, 0, 2'(m), 8'hA5);
    dir0("lsr7", 8'h80, 7, 2'b01, 8'h01);
    dir0("asr7", 8'h80, 7, 2'b10, 8'hFF);
    dir0("lsl7", 8'h01, 7, 2'b00, 8'h80);
    dir0("zero_lsr", 8'h0F, 4, 2'b01, 8'h00);
    dir0("zero_ror", 8'h0F, 4, 2'b11, 8'hF0);
    drain();

    ordy[1] = 1; iv[1] = 1;
    for (int k = 0; k < 18; k++) begin
      if (k == 16) iv[1] = 0;
      rnd(1);
      if (k < 16) chk("stream_ir", ir[1], 1);
      cyc();
      chk("stream_ov", ov[1], k >= 2);
    end
    drain();

    iv[1] = 1; rnd(1); cyc();
    rnd(1); cyc();
    iv[1] = 0; cyc();
    chk("bp_ov_pre", ov[1], 1);
    ordy[1] = 0; iv[1] = 1; rnd(1);
    hd = od[1];
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("bp_ov", ov[1], 1);
      chk("bp_od", od[1], hd);
      chk("bp_ir", ir[1], 0);
    end
    drain();

    for (int c = 0; c < 400; c++) begin
      for (int u = 0; u < 2; u++) begin
        iv[u] = $urandom_range(0, 3) != 0;
        ordy[u] = $urandom_range(0, 3) != 0;
        rnd(u);
      end
      cyc();
    end
    drain();

    ordy[1] = 1; iv[1] = 1;
    rnd(1); cyc();
    rnd(1); cyc();
    rnd(1); cyc();
    iv[1] = 0;
    chk("pre_rst_ov", ov[1], 1);
    #2 rst_n = 0;
    #1;
    chk("arst_ov", ov[1], 0);
    chk("arst_od", od[1], 0);
    chk("arst_oz", oz[1], 0);
    q[0].delete();
    q[1].delete();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_ir", ir[1], 1);
    for (int c = 0; c < 6; c++) begin
      cyc();
      chk("no_stale", ov[1], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
